fifo_wr_framer: RTL and testbench
=================================

# fifo_wr_framer

Write-side producer for the dual-clock FIFO, running entirely in the CLK_WR domain. It accepts a valid/ready payload stream from upstream logic and drives the FIFO write port, honouring FULL. After each frame's last payload word it inserts one trailer word holding a frame sequence number and a payload word count. A 2-entry skid buffer keeps S_READY registered, so the block sustains one word per cycle with no combinational path from FIFO_FULL to S_READY.

## Interface
- length, 16: FIFO data width; payload and trailer word width.
- CNT_W, 10: width of the trailer count field; must satisfy 1 ≤ CNT_W < length.
- CLK_WR  in  1  write-domain clock; all logic is on the rising edge.
- RESETN  in  1  reset, synchronous, active-low; clock CLK_WR.
- S_DATA  in  length  upstream payload word.
- S_VALID  in  1  upstream word valid.
- S_LAST  in  1  marks the last payload word of a frame; qualified by S_VALID.
- S_READY  out  1  block can accept a word; registered.
- FIFO_DATA  out  length  connects to the FIFO DATA_WR port.
- FIFO_WR  out  1  connects to the FIFO WR port.
- FIFO_FULL  in  1  connects to the FIFO FULL output.
- OVF  out  1  sticky flag: some frame exceeded the count range.

## Operation
- Accept: a beat is accepted on an edge where S_VALID && S_READY.
- Write: a word is written on an edge where FIFO_WR && !FIFO_FULL.
  - While FIFO_WR=1 and FIFO_FULL=1, FIFO_DATA and FIFO_WR hold unchanged.
- Storage: one output register (drives FIFO_DATA/FIFO_WR) plus one skid register.
  - S_READY = !skid_valid, registered.
- Output register load priority, evaluated on an edge where it is empty or being written:
  1. pending trailer;
  2. skid contents;
  3. the beat accepted on that edge.
- Trailer word = {seq[length-CNT_W-1:0], cnt[CNT_W-1:0]}.
  - cnt = number of payload beats accepted in the frame, including the LAST beat.
  - A frame therefore always has cnt ≥ 1.
- Trailer pending: set when the LAST beat is loaded into the output register; cleared when the trailer itself is loaded.
  - No payload beat is loaded between a LAST word and its trailer.
  - Beats accepted during this window wait in the skid register.
- Frame counting:
  - cnt resets to 0 when the trailer is loaded.
  - seq increments when the trailer is written to the FIFO and wraps modulo 2^(length-CNT_W).
- Saturation: cnt saturates at 2^CNT_W-1. An accepted beat while cnt is saturated sets OVF, which clears only on reset.
- S_LAST on successive beats is legal: each beat is a one-word frame with its own trailer.

## Timing
- Reset values (edge with RESETN=0): FIFO_WR=0, FIFO_DATA=0, S_READY=0, OVF=0, seq=0, cnt=0, skid and trailer-pending cleared. The first edge with RESETN=1 sets S_READY=1.
- Payload latency: a beat accepted on edge k appears on FIFO_DATA with FIFO_WR=1 after edge k, and is written on edge k+1 if FIFO_FULL=0.
- Trailer: a LAST word written on edge m is followed by the trailer on FIFO_DATA after edge m, written on edge m+1 if not full.
- Throughput: one word per cycle. Each trailer costs one input cycle: one beat is absorbed in the skid register, S_READY drops for one cycle, then recovers.
- Backpressure with FIFO_FULL stuck at 1: at most 2 further beats are accepted (output + skid), then S_READY=0 until a write occurs.
- Simultaneous events:
  - Accept and write on the same edge with an empty skid: the new beat goes to the output register and the skid stays empty.
  - LAST accept and trailer write on the same edge: both complete, and seq increments exactly once.
- Reset mid-frame: the partial frame is abandoned with no trailer. The FIFO shares RESETN, so it flushes as well.

## Test plan
- Reset: hold RESETN=0 for 3 edges with S_VALID=1 → FIFO_WR=0, FIFO_DATA=0, S_READY=0, OVF=0 throughout; S_READY=1 one edge after release.
- Single frame, FIFO_FULL=0: words 0x1111, 0x2222, 0x3333 (LAST on the third) → FIFO writes 0x1111, 0x2222, 0x3333, then trailer 0x0003; exactly one stall cycle on S_READY.
- Backpressure: FIFO_FULL=1 for 5 cycles mid-frame with S_VALID held → exactly 2 beats accepted, FIFO_DATA stable throughout; after release all words are written in order with no loss or duplication.
- Back-to-back frames: 2 frames of 1 word each (LAST every beat), continuous valid → write order P0, 0x0001, P1, 0x0401; seq 0 then 1 in bits [15:10].
- Overflow with CNT_W=4: 20-word frame → trailer count field 0xF, OVF=1 and held through the next clean frame.
- Sequence wrap, length=16, CNT_W=10: 65 one-word frames → 64th trailer carries seq 63, 65th trailer carries seq 0.

Source files
------------

// File: rtl/fifo_wr_framer.sv
// Write-side framer for the dual-clock FIFO: forwards a valid/ready payload stream
// to the FIFO write port and appends a {seq, count} trailer after every frame.
module fifo_wr_framer #(
  parameter int length = 16,
  parameter int CNT_W  = 10
) (
  input  logic              CLK_WR,
  input  logic              RESETN,
  input  logic [length-1:0] S_DATA,
  input  logic              S_VALID,
  input  logic              S_LAST,
  output logic              S_READY,
  output logic [length-1:0] FIFO_DATA,
  output logic              FIFO_WR,
  input  logic              FIFO_FULL,
  output logic              OVF
);

  localparam int SEQ_W = length - CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [length-1:0] r_out_data;
  logic [length-1:0] r_skid_data;
  logic              r_out_vld;
  logic              r_out_trl;
  logic              r_skid_vld;
  logic              r_skid_last;
  logic              r_trl_pend;
  logic              r_ovf;
  logic              r_ready;
  logic [CNT_W-1:0]  r_cnt;
  logic [SEQ_W-1:0]  r_seq;

  logic              w_wr;
  logic              w_acc;
  logic              w_load;
  logic              w_skid_ld;
  logic              w_pl_ld;
  logic [length-1:0] w_pl_data;
  logic              w_pl_last;
  logic [length-1:0] w_out_data;
  logic [length-1:0] w_skid_data;
  logic              w_out_vld;
  logic              w_out_trl;
  logic              w_skid_vld;
  logic              w_skid_last;
  logic              w_trl_pend;
  logic              w_ovf;
  logic [CNT_W-1:0]  w_cnt;
  logic [SEQ_W-1:0]  w_seq;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  assign w_wr   = r_out_vld && !FIFO_FULL;
  assign w_acc  = S_VALID && r_ready;
  assign w_load = !r_out_vld || w_wr;

  always_comb begin
    w_out_data  = r_out_data;
    w_out_vld   = r_out_vld;
    w_out_trl   = r_out_trl;
    w_skid_data = r_skid_data;
    w_skid_vld  = r_skid_vld;
    w_skid_last = r_skid_last;
    w_trl_pend  = r_trl_pend;
    w_cnt       = r_cnt;
    w_ovf       = r_ovf;
    w_seq       = r_seq;
    w_skid_ld   = 1'b0;
    w_pl_ld     = 1'b0;
    w_pl_data   = S_DATA;
    w_pl_last   = S_LAST;

    // Output register refill order: trailer, then skid, then the incoming beat.
    if (w_load) begin
      w_out_vld = 1'b0;
      w_out_trl = 1'b0;
      if (r_trl_pend) begin
        w_out_data = {r_seq, r_cnt};
        w_out_vld  = 1'b1;
        w_out_trl  = 1'b1;
        w_trl_pend = 1'b0;
        w_cnt      = '0;
        w_skid_ld  = w_acc;
      end else if (r_skid_vld) begin
        w_pl_ld    = 1'b1;
        w_pl_data  = r_skid_data;
        w_pl_last  = r_skid_last;
        w_skid_vld = 1'b0;
        w_skid_ld  = w_acc;
      end else begin
        w_pl_ld = w_acc;
      end
    end else begin
      w_skid_ld = w_acc;
    end

    if (w_skid_ld) begin
      w_skid_data = S_DATA;
      w_skid_last = S_LAST;
      w_skid_vld  = 1'b1;
    end

    // Beats are counted as they enter the output register, which keeps frame order.
    if (w_pl_ld) begin
      w_out_data = w_pl_data;
      w_out_vld  = 1'b1;
      w_out_trl  = 1'b0;
      w_trl_pend = w_pl_last;
      w_cnt      = sat_inc(r_cnt);
      if (r_cnt == CNT_MAX) w_ovf = 1'b1;
    end

    if (w_wr && r_out_trl) w_seq = r_seq + SEQ_W'(1);
  end

  always_ff @(posedge CLK_WR) begin
    if (!RESETN) begin
      r_out_data  <= '0;
      r_out_vld   <= 1'b0;
      r_out_trl   <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_last <= 1'b0;
      r_trl_pend  <= 1'b0;
      r_ovf       <= 1'b0;
      r_ready     <= 1'b0;
      r_cnt       <= '0;
      r_seq       <= '0;
    end else begin
      r_out_data  <= w_out_data;
      r_out_vld   <= w_out_vld;
      r_out_trl   <= w_out_trl;
      r_skid_vld  <= w_skid_vld;
      r_skid_last <= w_skid_last;
      r_trl_pend  <= w_trl_pend;
      r_ovf       <= w_ovf;
      r_ready     <= !w_skid_vld;
      r_cnt       <= w_cnt;
      r_seq       <= w_seq;
    end
  end

  always_ff @(posedge CLK_WR) begin
    r_skid_data <= w_skid_data;
  end

  assign S_READY   = r_ready;
  assign FIFO_DATA = r_out_data;
  assign FIFO_WR   = r_out_vld;
  assign OVF       = r_ovf;

endmodule

// File: tb/tb_fifo_wr_framer.sv
// Directed bench for fifo_wr_framer: one instance with CNT_W=10, one with CNT_W=4,
// sharing all inputs; words written to the FIFO are collected per instance.
module tb_fifo_wr_framer;

  logic        CLK_WR    = 1'b0;
  logic        RESETN    = 1'b0;
  logic [15:0] S_DATA    = '0;
  logic        S_VALID   = 1'b0;
  logic        S_LAST    = 1'b0;
  logic        FIFO_FULL = 1'b0;

  logic        rdy0, wr0, ovf0;
  logic [15:0] dat0;
  logic        rdy4, wr4, ovf4;
  logic [15:0] dat4;

  int n_tests = 0;
  int n_fail  = 0;
  int n_stall = 0;
  logic [15:0] q0[$];
  logic [15:0] q4[$];

  fifo_wr_framer #(.length(16), .CNT_W(10)) u_dut (
    .CLK_WR(CLK_WR), .RESETN(RESETN), .S_DATA(S_DATA), .S_VALID(S_VALID),
    .S_LAST(S_LAST), .S_READY(rdy0), .FIFO_DATA(dat0), .FIFO_WR(wr0),
    .FIFO_FULL(FIFO_FULL), .OVF(ovf0)
  );

  fifo_wr_framer #(.length(16), .CNT_W(4)) u_dut4 (
    .CLK_WR(CLK_WR), .RESETN(RESETN), .S_DATA(S_DATA), .S_VALID(S_VALID),
    .S_LAST(S_LAST), .S_READY(rdy4), .FIFO_DATA(dat4), .FIFO_WR(wr4),
    .FIFO_FULL(FIFO_FULL), .OVF(ovf4)
  );

  always #5 CLK_WR = ~CLK_WR;

  // Inputs change just after the rising edge, so the falling edge shows what the next edge does.
  always @(negedge CLK_WR) begin
    if (RESETN) begin
      if (wr0 && !FIFO_FULL) q0.push_back(dat0);
      if (wr4 && !FIFO_FULL) q4.push_back(dat4);
      if (S_VALID && !rdy0) n_stall++;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1);
  end

  task automatic push(input logic [15:0] d, input logic l);
    bit acc;
    int n;
    S_VALID = 1'b1;
    S_DATA  = d;
    S_LAST  = l;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge CLK_WR);
      acc = rdy0;
      @(posedge CLK_WR);
      #1;
      n++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout data=%h got_ready=%b required=1", d, rdy0);
    end
  endtask

  task automatic idle(input int n);
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
    repeat (n) begin
      @(posedge CLK_WR);
      #1;
    end
  endtask

  task automatic do_reset();
    S_VALID   = 1'b0;
    S_LAST    = 1'b0;
    FIFO_FULL = 1'b0;
    RESETN    = 1'b0;
    repeat (2) @(posedge CLK_WR);
    #1;
    RESETN = 1'b1;
    @(posedge CLK_WR);
    #1;
    q0.delete();
    q4.delete();
    n_stall = 0;
  endtask

  task automatic test_reset();
    RESETN  = 1'b0;
    S_VALID = 1'b1;
    S_DATA  = 16'h5A5A;
    S_LAST  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK_WR);
      #1;
      n_tests++;
      if (wr0 !== 1'b0) begin n_fail++; $display("FAIL reset_wr cyc=%0d got=%b required=0", i, wr0); end
      n_tests++;
      if (dat0 !== 16'h0000) begin n_fail++; $display("FAIL reset_data cyc=%0d got=%h required=0000", i, dat0); end
      n_tests++;
      if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL reset_ready cyc=%0d got=%b required=0", i, rdy0); end
      n_tests++;
      if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf cyc=%0d got=%b required=0", i, ovf0); end
    end
    RESETN  = 1'b1;
    S_VALID = 1'b0;
    @(posedge CLK_WR);
    #1;
    n_tests++;
    if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b required=1", rdy0); end
  endtask

  task automatic test_single_frame();
    logic [15:0] exp [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h0003,
                             16'h4444, 16'h5555, 16'h6666, 16'h0403};
    int stalls;
    q0.delete();
    n_stall = 0;
    push(16'h1111, 1'b0);
    push(16'h2222, 1'b0);
    push(16'h3333, 1'b1);
    push(16'h4444, 1'b0);
    push(16'h5555, 1'b0);
    stalls = n_stall;
    push(16'h6666, 1'b1);
    idle(8);
    n_tests++;
    if (stalls !== 1) begin n_fail++; $display("FAIL single_stall_cycles got=%0d required=1", stalls); end
    n_tests++;
    if (q0.size() !== 8) begin n_fail++; $display("FAIL single_write_count got=%0d required=8", q0.size()); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (q0[i] !== exp[i]) begin n_fail++; $display("FAIL single_word[%0d] got=%h required=%h", i, q0[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp [5] = '{16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'h0804};
    int  acc;
    bit  took;
    q0.delete();
    push(16'hB001, 1'b0);
    idle(3);
    FIFO_FULL = 1'b1;
    S_VALID   = 1'b1;
    S_DATA    = 16'hB002;
    S_LAST    = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_WR);
      took = S_VALID && rdy0;
      if (i >= 1) begin
        n_tests++;
        if (dat0 !== 16'hB002 || wr0 !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_hold cyc=%0d got=%h/%b required=b002/1", i, dat0, wr0);
        end
      end
      @(posedge CLK_WR);
      #1;
      if (took) begin
        acc++;
        S_DATA = 16'hB002 + 16'(acc);
        S_LAST = (acc == 2);
      end
    end
    n_tests++;
    if (acc !== 2) begin n_fail++; $display("FAIL bp_accepted got=%0d required=2", acc); end
    FIFO_FULL = 1'b0;
    push(16'hB004, 1'b1);
    idle(8);
    n_tests++;
    if (q0.size() !== 5) begin n_fail++; $display("FAIL bp_write_count got=%0d required=5", q0.size()); end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (q0[i] !== exp[i]) begin n_fail++; $display("FAIL bp_word[%0d] got=%h required=%h", i, q0[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [4] = '{16'hC0DE, 16'h0001, 16'hBEEF, 16'h0401};
    do_reset();
    push(16'hC0DE, 1'b1);
    push(16'hBEEF, 1'b1);
    idle(8);
    n_tests++;
    if (q0.size() !== 4) begin n_fail++; $display("FAIL b2b_write_count got=%0d required=4", q0.size()); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (q0[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_word[%0d] got=%h required=%h", i, q0[i], exp[i]); end
    end
    n_tests++;
    if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf got=%b required=0", ovf0); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) push(16'hD000 + 16'(i), (i == 19));
    idle(6);
    n_tests++;
    if (q4.size() !== 21) begin n_fail++; $display("FAIL ovf_write_count got=%0d required=21", q4.size()); end
    n_tests++;
    if (q4[19] !== 16'hD013) begin n_fail++; $display("FAIL ovf_last_payload got=%h required=d013", q4[19]); end
    n_tests++;
    if (q4[20] !== 16'h000F) begin n_fail++; $display("FAIL ovf_trailer got=%h required=000f", q4[20]); end
    n_tests++;
    if (ovf4 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b required=1", ovf4); end
    n_tests++;
    if (q0[20] !== 16'h0014) begin n_fail++; $display("FAIL ovf_wide_trailer got=%h required=0014", q0[20]); end
    n_tests++;
    if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL ovf_wide_flag got=%b required=0", ovf0); end
    push(16'hE000, 1'b0);
    push(16'hE001, 1'b1);
    idle(8);
    n_tests++;
    if (q4.size() !== 24) begin n_fail++; $display("FAIL ovf_clean_count got=%0d required=24", q4.size()); end
    n_tests++;
    if (q4[23] !== 16'h0012) begin n_fail++; $display("FAIL ovf_clean_trailer got=%h required=0012", q4[23]); end
    n_tests++;
    if (ovf4 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b required=1", ovf4); end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    for (int i = 0; i < 65; i++) push(16'(i), 1'b1);
    idle(8);
    n_tests++;
    if (q0.size() !== 130) begin n_fail++; $display("FAIL wrap_write_count got=%0d required=130", q0.size()); end
    n_tests++;
    if (q0[126] !== 16'h003F) begin n_fail++; $display("FAIL wrap_payload63 got=%h required=003f", q0[126]); end
    n_tests++;
    if (q0[127] !== 16'hFC01) begin n_fail++; $display("FAIL wrap_trailer64 got=%h required=fc01", q0[127]); end
    n_tests++;
    if (q0[128] !== 16'h0040) begin n_fail++; $display("FAIL wrap_payload64 got=%h required=0040", q0[128]); end
    n_tests++;
    if (q0[129] !== 16'h0001) begin n_fail++; $display("FAIL wrap_trailer65 got=%h required=0001", q0[129]); end
  endtask

  task automatic test_reset_mid_frame();
    push(16'h7001, 1'b0);
    push(16'h7002, 1'b0);
    do_reset();
    push(16'h7003, 1'b1);
    idle(8);
    n_tests++;
    if (q0.size() !== 2) begin n_fail++; $display("FAIL midrst_write_count got=%0d required=2", q0.size()); end
    n_tests++;
    if (q0[0] !== 16'h7003) begin n_fail++; $display("FAIL midrst_payload got=%h required=7003", q0[0]); end
    n_tests++;
    if (q0[1] !== 16'h0001) begin n_fail++; $display("FAIL midrst_trailer got=%h required=0001", q0[1]); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_seq_wrap();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
